// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC sample scheduler.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam int unsigned DAC_DATA_W = 8;
    localparam int unsigned MISS_W     = 8;
    localparam logic [MISS_W-1:0] MISS_MAX = 8'hFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after ptr, wrapping upward.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any_grant
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [31:0] cand;

    always_comb begin
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any_grant && req[IDX_W'(cand)]) begin
                any_grant             = 1'b1;
                idx                   = IDX_W'(cand);
                grant[IDX_W'(cand)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Paces a shared serial DAC: one round-robin grant per update slot, then start/done handshake.
// Optional driver-timeout abort is built when DAC_SCHED_TIMEOUT_EN is defined.
module dac_sample_scheduler
    import dac_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned DATA_W        = DAC_DATA_W,
    parameter int unsigned UPDATE_PERIOD = 256
`ifdef DAC_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC   = 64
`endif
) (
    input  logic                        clk_50M,
    input  logic                        locked,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        dac_start,
    output logic [DATA_W-1:0]           dac_data,
    input  logic                        dac_done,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic [MISS_W-1:0]           miss_cnt,
    output logic                        timeout_err
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned PCNT_W = $clog2(UPDATE_PERIOD);

    state_e              state_q, state_d;
    logic [PCNT_W-1:0]   period_cnt_q;
    logic                slot_open_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [DATA_W-1:0]   dac_data_q;
    logic [IDX_W-1:0]    grant_id_q;
    logic                dac_start_q;
    logic                busy_q;
    logic [MISS_W-1:0]   miss_q;

    logic [NUM_REQ-1:0]  grant_oh_c;
    logic [IDX_W-1:0]    grant_idx_c;
    logic                any_grant_c;
    logic                accept_c;
    logic                tick_c;
    logic                wait_expired_c;
    logic [DATA_W-1:0]   win_data_c;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant_oh_c),
        .idx       (grant_idx_c),
        .any_grant (any_grant_c)
    );

    assign tick_c    = (period_cnt_q == PCNT_W'(UPDATE_PERIOD - 1));
    assign accept_c  = (state_q == IDLE) && slot_open_q && any_grant_c;
    assign req_ready = accept_c ? grant_oh_c : '0;

    always_comb begin
        win_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_oh_c[i]) begin
                win_data_c = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic; a done pulse takes priority over a timeout abort.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept_c) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (dac_done || wait_expired_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge locked) begin
        if (!locked) begin
            state_q      <= IDLE;
            period_cnt_q <= '0;
            slot_open_q  <= 1'b0;
            rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
            dac_data_q   <= '0;
            grant_id_q   <= '0;
            dac_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= tick_c ? '0 : period_cnt_q + PCNT_W'(1);
            dac_start_q  <= (state_d == START);
            busy_q       <= (state_d == START) || (state_d == WAIT);
            // A tick coinciding with an accept opens a fresh slot.
            if (tick_c) begin
                slot_open_q <= 1'b1;
            end else if (accept_c) begin
                slot_open_q <= 1'b0;
            end
            if (tick_c && slot_open_q && !accept_c && (miss_q != MISS_MAX)) begin
                miss_q <= miss_q + MISS_W'(1);
            end
            if (accept_c) begin
                dac_data_q <= win_data_c;
                grant_id_q <= grant_idx_c;
                rr_ptr_q   <= grant_idx_c;
            end
        end
    end

`ifdef DAC_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] wait_cnt_q;
    logic            timeout_err_q;

    assign wait_expired_c = (wait_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_50M or negedge locked) begin
        if (!locked) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q <= ((state_q == WAIT) && (state_d == WAIT)) ? wait_cnt_q + TO_W'(1) : '0;
            if ((state_q == WAIT) && !dac_done && wait_expired_c) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign wait_expired_c = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    assign dac_start = dac_start_q;
    assign dac_data  = dac_data_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;
    assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler with a small DAC-driver model answering dac_start.
module tb_dac_sample_scheduler;

    logic        clk_50M = 1'b0;
    logic        locked;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        dac_start;
    logic [7:0]  dac_data;
    logic        dac_done;
    logic [0:0]  grant_id;
    logic        busy;
    logic [7:0]  miss_cnt;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_at = -1;
    int done_lat = -1;
    int start_cnt = 0;
    int busy_cnt  = 0;

    always #10 clk_50M = ~clk_50M;

    dac_sample_scheduler #(
        .NUM_REQ       (2),
        .DATA_W        (8),
        .UPDATE_PERIOD (8)
`ifdef DAC_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT_CYC   (16)
`endif
    ) dut (
        .clk_50M     (clk_50M),
        .locked      (locked),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .dac_start   (dac_start),
        .dac_data    (dac_data),
        .dac_done    (dac_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .miss_cnt    (miss_cnt),
        .timeout_err (timeout_err)
    );

    typedef struct {
        int         scen;
        int         cyc;
        logic [1:0] ready;
        logic       start;
        logic       busy;
        logic [7:0] data;
        logic       gid;
        logic [7:0] miss;
        logic       terr;
    } chk_t;

    chk_t chks[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_start"}, 32'(dac_start), 32'd0);
        check({tag, "_data"},  32'(dac_data),  32'd0);
        check({tag, "_gid"},   32'(grant_id),  32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_miss"},  32'(miss_cnt),  32'd0);
        check({tag, "_terr"},  32'(timeout_err), 32'd0);
    endtask

    // Hold reset one cycle, then release right after an edge; the current cycle becomes cycle 0.
    task automatic do_reset();
        locked    = 1'b0;
        req_valid = 2'b00;
        dac_done  = 1'b0;
        done_at   = -1;
        @(posedge clk_50M);
        #3;
        check_zero_outputs("rst");
        @(posedge clk_50M);
        #1;
        locked    = 1'b1;
        cyc       = 0;
        start_cnt = 0;
        busy_cnt  = 0;
    endtask

    // One clock: drive inputs just after the edge, then sample and run the driver model.
    task automatic run_cycle(input logic [1:0] v);
        @(posedge clk_50M);
        #1;
        cyc++;
        req_valid = v;
        dac_done  = (cyc == done_at);
        #2;
        if (dac_start) begin
            start_cnt++;
            if (done_lat >= 0) done_at = cyc + done_lat;
        end
        if (busy) busy_cnt++;
    endtask

    task automatic apply_checks(input int id);
        foreach (chks[k]) begin
            if (chks[k].scen == id && chks[k].cyc == cyc) begin
                check($sformatf("s%0d_ready", id), 32'(req_ready),   32'(chks[k].ready));
                check($sformatf("s%0d_start", id), 32'(dac_start),   32'(chks[k].start));
                check($sformatf("s%0d_busy",  id), 32'(busy),        32'(chks[k].busy));
                check($sformatf("s%0d_data",  id), 32'(dac_data),    32'(chks[k].data));
                check($sformatf("s%0d_gid",   id), 32'(grant_id),    32'(chks[k].gid));
                check($sformatf("s%0d_miss",  id), 32'(miss_cnt),    32'(chks[k].miss));
                check($sformatf("s%0d_terr",  id), 32'(timeout_err), 32'(chks[k].terr));
            end
        end
    endtask

    task automatic run_scen(input int id, input int ncyc, input int v0_from, input int v0_to,
                            input int v1_from, input int v1_to, input int lat,
                            input logic [15:0] data);
        do_reset();
        req_data = data;
        done_lat = lat;
        for (int c = 1; c <= ncyc; c++) begin
            run_cycle({(c >= v1_from && c < v1_to), (c >= v0_from && c < v0_to)});
            apply_checks(id);
        end
    endtask

    initial begin
        locked    = 1'b0;
        req_valid = 2'b00;
        req_data  = 16'h0000;
        dac_done  = 1'b0;

        //                scen cyc  ready start busy data   gid miss  terr
        chks.push_back(chk_t'{1,  7, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0});
        chks.push_back(chk_t'{1,  8, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0});
        chks.push_back(chk_t'{1,  9, 2'b00, 1'b1, 1'b1, 8'hA5, 1'b0, 8'd0, 1'b0});
        chks.push_back(chk_t'{1, 10, 2'b00, 1'b0, 1'b1, 8'hA5, 1'b0, 8'd0, 1'b0});
        chks.push_back(chk_t'{1, 19, 2'b00, 1'b0, 1'b1, 8'hA5, 1'b0, 8'd0, 1'b0});
        chks.push_back(chk_t'{1, 20, 2'b01, 1'b0, 1'b0, 8'hA5, 1'b0, 8'd0, 1'b0});
        chks.push_back(chk_t'{2,  8, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0});
        chks.push_back(chk_t'{2,  9, 2'b00, 1'b1, 1'b1, 8'h11, 1'b0, 8'd0, 1'b0});
        chks.push_back(chk_t'{2, 13, 2'b00, 1'b0, 1'b0, 8'h11, 1'b0, 8'd0, 1'b0});
        chks.push_back(chk_t'{2, 16, 2'b10, 1'b0, 1'b0, 8'h11, 1'b0, 8'd0, 1'b0});
        chks.push_back(chk_t'{2, 17, 2'b00, 1'b1, 1'b1, 8'h22, 1'b1, 8'd0, 1'b0});
        chks.push_back(chk_t'{2, 24, 2'b01, 1'b0, 1'b0, 8'h22, 1'b1, 8'd0, 1'b0});
        chks.push_back(chk_t'{2, 25, 2'b00, 1'b1, 1'b1, 8'h11, 1'b0, 8'd0, 1'b0});
        chks.push_back(chk_t'{2, 33, 2'b00, 1'b1, 1'b1, 8'h22, 1'b1, 8'd0, 1'b0});
        chks.push_back(chk_t'{3, 15, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0});
        chks.push_back(chk_t'{3, 16, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd1, 1'b0});
        chks.push_back(chk_t'{3, 24, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd2, 1'b0});
        chks.push_back(chk_t'{3, 26, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0, 8'd2, 1'b0});
        chks.push_back(chk_t'{3, 27, 2'b00, 1'b1, 1'b1, 8'h22, 1'b1, 8'd2, 1'b0});
        chks.push_back(chk_t'{3, 33, 2'b00, 1'b1, 1'b1, 8'h22, 1'b1, 8'd2, 1'b0});
        chks.push_back(chk_t'{4, 24, 2'b00, 1'b0, 1'b1, 8'h11, 1'b0, 8'd1, 1'b0});
        chks.push_back(chk_t'{4, 29, 2'b00, 1'b0, 1'b1, 8'h11, 1'b0, 8'd1, 1'b0});
        chks.push_back(chk_t'{4, 30, 2'b10, 1'b0, 1'b0, 8'h11, 1'b0, 8'd1, 1'b0});
        chks.push_back(chk_t'{4, 31, 2'b00, 1'b1, 1'b1, 8'h22, 1'b1, 8'd1, 1'b0});
`ifdef DAC_SCHED_TIMEOUT_EN
        chks.push_back(chk_t'{5, 25, 2'b00, 1'b0, 1'b1, 8'hA5, 1'b0, 8'd1, 1'b0});
        chks.push_back(chk_t'{5, 26, 2'b01, 1'b0, 1'b0, 8'hA5, 1'b0, 8'd1, 1'b1});
        chks.push_back(chk_t'{5, 27, 2'b00, 1'b1, 1'b1, 8'hA5, 1'b0, 8'd1, 1'b1});
`else
        chks.push_back(chk_t'{5, 25, 2'b00, 1'b0, 1'b1, 8'hA5, 1'b0, 8'd1, 1'b0});
        chks.push_back(chk_t'{5, 26, 2'b00, 1'b0, 1'b1, 8'hA5, 1'b0, 8'd1, 1'b0});
        chks.push_back(chk_t'{5, 40, 2'b00, 1'b0, 1'b1, 8'hA5, 1'b0, 8'd3, 1'b0});
`endif

        // Single requester, done 10 cycles after start.
        run_scen(1, 20, 0, 1000, 1000, 1000, 10, 16'h5AA5);
        check("s1_busy_cycles", 32'(busy_cnt), 32'd11);

        // Both valid: alternating grants, one start per period.
        run_scen(2, 34, 0, 1000, 0, 1000, 3, 16'h2211);
        check("s2_start_count", 32'(start_cnt), 32'd4);

        // Idle through three ticks, then requester 1 rises.
        run_scen(3, 34, 1000, 1000, 26, 1000, 3, 16'h2211);

        // Slow driver: no overlap, one missed slot.
        run_scen(4, 31, 0, 1000, 0, 1000, 20, 16'h2211);
        check("s4_start_count", 32'(start_cnt), 32'd2);

        // Driver never answers.
        run_scen(5, 40, 0, 1000, 1000, 1000, -1, 16'h5AA5);

        // Asynchronous reset during START, then during WAIT.
        do_reset();
        req_data = 16'h2211;
        done_lat = -1;
        for (int c = 1; c <= 9; c++) run_cycle(2'b11);
        check("s6_start_pre", 32'(dac_start), 32'd1);
        #4;
        locked = 1'b0;
        #1;
        check_zero_outputs("s6_start_rst");
        #10;
        @(posedge clk_50M);
        #1;
        locked = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 8; c++) run_cycle(2'b11);
        check("s6_ready_a", 32'(req_ready), 32'd1);
        for (int c = 9; c <= 12; c++) run_cycle(2'b11);
        check("s6_busy_pre", 32'(busy), 32'd1);
        check("s6_data_pre", 32'(dac_data), 32'h11);
        #4;
        locked = 1'b0;
        #1;
        check_zero_outputs("s6_wait_rst");
        @(posedge clk_50M);
        #1;
        locked = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 8; c++) run_cycle(2'b11);
        check("s6_ready_b", 32'(req_ready), 32'd1);
        run_cycle(2'b11);
        check("s6_start_b", 32'(dac_start), 32'd1);
        check("s6_data_b", 32'(dac_data), 32'h11);
        check("s6_gid_b", 32'(grant_id), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
